// File: rtl/sync_fifo_gen2_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_gen2_pkg
//   Shared definitions for the generalised single-clock FIFO: default
//   geometry, width helpers for the count/threshold and pointer buses, and
//   the packed status word used by the FIFO and its testbench.
//   Optional feature macro: SYNC_FIFO_GEN2_FWFT_EN (see sync_fifo_gen2.sv).
// ----------------------------------------------------------------------------
package sync_fifo_gen2_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    // Width able to hold every occupancy value 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width able to address entries 0..depth-1 (never narrower than 1 bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
        logic overflow;
        logic underflow;
        logic wr_ack;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_gen2_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_gen2_if
//   Handshake/data bundle between a producer/consumer and the FIFO.
//   Parameters: WIDTH (data word), DEPTH (entries); CNT_W is derived.
//   Modports:
//     master : drives wr_en, data_in, rd_en, afull_thr, aempty_thr;
//              observes data_out, rd_valid, wr_ack, overflow, underflow,
//              full, empty, almostfull, almostempty, count.
//     slave  : the FIFO side, directions mirrored.
// ----------------------------------------------------------------------------
interface sync_fifo_gen2_if
    import sync_fifo_gen2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [CNT_W-1:0] afull_thr;
    logic [CNT_W-1:0] aempty_thr;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             wr_ack;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic [CNT_W-1:0] count;

    modport master (
        output wr_en, data_in, rd_en, afull_thr, aempty_thr,
        input  data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  wr_en, data_in, rd_en, afull_thr, aempty_thr,
        output data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

endinterface

// File: rtl/sync_fifo_gen2_ram.sv
// ----------------------------------------------------------------------------
// sync_fifo_gen2_ram
//   DEPTH x WIDTH simple dual-port storage: synchronous write, asynchronous
//   read. Address range is 0..DEPTH-1; DEPTH need not be a power of two.
//   Ports:
//     clk    in   clock, rising edge
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address
//     rdata  out  read data (combinational from raddr)
// ----------------------------------------------------------------------------
module sync_fifo_gen2_ram
    import sync_fifo_gen2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; contents are only meaningful once the
    // pointers say so, and a reset-free array maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen2.sv
// ----------------------------------------------------------------------------
// sync_fifo_gen2
//   Parametrised single-clock FIFO with run-time almost-full / almost-empty
//   thresholds, write-through when full with a simultaneous read, and an
//   exposed occupancy count.
//   Parameters: WIDTH (>=1), DEPTH (>=2, any integer).
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  asynchronous, active-high reset
//     bus  sync_fifo_gen2_if.slave (data, handshake, thresholds, status)
//   Configuration macro SYNC_FIFO_GEN2_FWFT_EN:
//     defined   -> first-word-fall-through: data_out shows the head entry
//                  combinationally, rd_valid = !empty, rd_en pops it.
//     undefined -> registered read: data_out loads the head on an accepted
//                  read (1-cycle latency), rd_valid pulses alongside.
//   Status and acknowledge timing is identical in both modes.
// ----------------------------------------------------------------------------
module sync_fifo_gen2
    import sync_fifo_gen2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_gen2_if.slave  bus
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] ram_rdata;

    logic             full;
    logic             empty;
    logic             wr_ok;
    logic             rd_ok;
    logic             afull_en;
    logic             aempty_en;

    logic             wr_ack_q;
    logic             overflow_q;
    logic             underflow_q;

    fifo_status_t     status;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // A read while full frees a slot in the same cycle, so the write is
    // accepted too and the count stays put.
    assign rd_ok = bus.rd_en && !empty;
    assign wr_ok = bus.wr_en && (!full || bus.rd_en);

    // Thresholds of 0 or above DEPTH disable their flag.
    assign afull_en  = (bus.afull_thr  != '0) && (bus.afull_thr  <= DEPTH_CNT);
    assign aempty_en = (bus.aempty_thr != '0) && (bus.aempty_thr <= DEPTH_CNT);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            wr_ack_q    <= wr_ok;
            overflow_q  <= bus.wr_en && !wr_ok;
            underflow_q <= bus.rd_en && empty;
        end
    end

    sync_fifo_gen2_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

`ifdef SYNC_FIFO_GEN2_FWFT_EN
    // Head entry is presented directly; rd_en acknowledges it.
    assign bus.data_out = ram_rdata;
    assign bus.rd_valid = !empty;
`else
    logic [WIDTH-1:0] data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (rd_ok) begin
                data_q <= ram_rdata;
            end
            rd_valid_q <= rd_ok;
        end
    end

    assign bus.data_out = data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    // NOTE: a default assignment first keeps this block free of latches.
    always_comb begin
        status             = '0;
        status.full        = full;
        status.empty       = empty;
        status.almostfull  = afull_en && (count >= bus.afull_thr) && !full;
        status.almostempty = aempty_en && (count <= bus.aempty_thr) && !empty;
        status.overflow    = overflow_q;
        status.underflow   = underflow_q;
        status.wr_ack      = wr_ack_q;
    end

    assign bus.full        = status.full;
    assign bus.empty       = status.empty;
    assign bus.almostfull  = status.almostfull;
    assign bus.almostempty = status.almostempty;
    assign bus.overflow    = status.overflow;
    assign bus.underflow   = status.underflow;
    assign bus.wr_ack      = status.wr_ack;
    assign bus.count       = count;

endmodule
